uart_imem_loader: RTL

- Boot loader that sits directly upstream of the instruction memory's write port.
- Takes bytes from the UART receiver, frames them into 32-bit instruction words, and writes them sequentially from word 0.
- Holds the RISC-V core in reset until a complete program with a valid checksum has been written.
- After a successful load it locks and ignores further UART traffic until the next system reset.

---
 rtl/uart_imem_loader_if.sv | 27 ++
 rtl/uart_imem_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader_if.sv
// UART byte stream in, instruction-memory write port out.
// The loader uses the master view; the environment uses the slave view.
interface uart_imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );
endinterface

// File: rtl/uart_imem_loader.sv
// Frames UART bytes into instruction words, writes them from word 0,
// and releases the core from reset once the checksum matches.
module uart_imem_loader #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic reset,
  uart_imem_loader_if.master bus,
  output logic cpu_reset,
  output logic load_done,
  output logic load_err
);

  localparam logic [7:0] HDR   = 8'hA5;
  localparam logic [8:0] DEP9  = 9'(DEPTH);
  localparam int         TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, CHECK, DONE, ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, done_q, err_q;
  logic              rx_v;
  logic [7:0]        rx_b;
  logic              in_frame;
  logic              expire;

  assign rx_v = bus.rx_valid;
  assign rx_b = bus.rx_data;

  assign in_frame = (state_q == COUNT) ||
                    (state_q == DATA) ||
                    (state_q == CHECK);
  assign expire   = in_frame && !rx_v && (idle_q == TLAST);

  // Next-state, framing, checksum and write-port decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    idle_d  = '0;
    if (in_frame && !rx_v) idle_d = idle_q + 1'b1;
    unique case (state_q)
      IDLE, ERROR: begin
        if (rx_v && rx_b == HDR) begin
          state_d = COUNT;
          csum_d  = '0;
          widx_d  = '0;
          bidx_d  = '0;
        end
      end
      COUNT: begin
        if (rx_v) begin
          if (rx_b == 8'd0 || {1'b0, rx_b} > DEP9) begin
            state_d = ERROR;
          end else begin
            cnt_d   = rx_b;
            state_d = DATA;
          end
        end else if (expire) begin
          state_d = ERROR;
        end
      end
      DATA: begin
        if (rx_v) begin
          csum_d = csum_q ^ rx_b;
          bidx_d = bidx_q + 2'd1;
          asm_d  = {rx_b, asm_q[23:8]};
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = widx_q[ADDR_W-1:0];
            wdata_d = {rx_b, asm_q};
            widx_d  = widx_q + 8'd1;
            if (widx_q + 8'd1 == cnt_q) state_d = CHECK;
          end
        end else if (expire) begin
          state_d = ERROR;
        end
      end
      CHECK: begin
        if (rx_v) begin
          state_d = (rx_b == csum_q) ? DONE : ERROR;
        end else if (expire) begin
          state_d = ERROR;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      widx_q    <= '0;
      bidx_q    <= '0;
      asm_q     <= '0;
      csum_q    <= '0;
      idle_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      bidx_q    <= bidx_d;
      asm_q     <= asm_d;
      csum_q    <= csum_d;
      idle_q    <= idle_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= (state_d != DONE);
      done_q    <= (state_d == DONE);
      err_q     <= (state_d == ERROR);
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_reset     = cpu_rst_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule
